// File: rtl/atomik_loader_pkg.sv
// atomik_loader_pkg: shared constants, parser states and baud helper for the genome loader
package atomik_loader_pkg;
  localparam logic [7:0] MAGIC_A = 8'h41;
  localparam logic [7:0] MAGIC_T = 8'h54;
  localparam logic [7:0] MAGIC_O = 8'h4F;
  localparam logic [7:0] MAGIC_M = 8'h4D;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAGIC,
    ST_VERSION,
    ST_FREQ,
    ST_POLICY,
`ifdef ATOMIK_LOADER_CHECKSUM_EN
    ST_DNA,
    ST_CSUM
`else
    ST_DNA
`endif
  } state_t;
  function automatic logic [15:0] phase_inc(input longint clk_freq, input longint baud);
    longint v;
    v = (baud * 64'd1048576 + clk_freq / 2) / clk_freq;
    return v < 1 ? 16'd1 : v > 65535 ? 16'hFFFF : v[15:0];
  endfunction
endpackage

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: synchronised, majority-voted 16x oversampling UART receiver
module uart_rx_os16
  import atomik_loader_pkg::*;
#(
  parameter int CLK_FREQ  = 27000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam logic [15:0] INC = phase_inc(CLK_FREQ, BAUD_RATE);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t   st_q, st_d;
  logic [2:0]  sync_q, sync_d, bit_q, bit_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        bv_q, bv_d, fe_q, fe_d, tick, rx_m;
  always_comb begin
    sync_d = {sync_q[1:0], uart_rx};
    rx_m = (sync_q[0] & sync_q[1]) | (sync_q[1] & sync_q[2]) | (sync_q[0] & sync_q[2]);
    {tick, acc_d} = {1'b0, acc_q} + {1'b0, INC};
    st_d = st_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    bv_d = 1'b0;
    fe_d = 1'b0;
    if (tick) begin
      cnt_d = cnt_q + 4'd1;
      case (st_q)
        RX_IDLE: begin
          cnt_d = '0;
          st_d = rx_m ? RX_IDLE : RX_START;
        end
        RX_START: if (cnt_q == 4'd7) begin
          cnt_d = '0;
          bit_d = '0;
          st_d = rx_m ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt_q == 4'd15) begin
          sh_d = {rx_m, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          st_d = bit_q == 3'd7 ? RX_STOP : RX_DATA;
        end
        RX_STOP: if (cnt_q == 4'd15) begin
          bv_d = rx_m;
          fe_d = ~rx_m;
          st_d = RX_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
      acc_q <= '0;
      st_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      bv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      acc_q <= acc_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      bv_q <= bv_d;
      fe_q <= fe_d;
    end
  end
  assign byte_valid = bv_q;
  assign frame_err = fe_q;
  assign rx_byte = sh_q;
endmodule

// File: rtl/uart_genome_loader_mc.sv
// uart_genome_loader_mc: framed multi-channel genome loader with atomic shadow-to-output commit.
// Define ATOMIK_LOADER_CHECKSUM_EN to require the trailing XOR checksum byte.
module uart_genome_loader_mc
  import atomik_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int NUM_CH      = 2,
  parameter int DNA_BYTES   = 32,
  parameter int TIMEOUT_CYC = 2700000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_rx,
  output logic [NUM_CH*32-1:0]   poly_freq_out,
  output logic [DNA_BYTES*8-1:0] dna_storage,
  output logic                   otp_en,
  output logic                   core_enable,
  output logic                   loader_busy,
  output logic                   load_done,
  output logic                   load_err,
  output logic [1:0]             err_code
);
  localparam int FREQ_W = NUM_CH * 32;
  localparam int DNA_W  = DNA_BYTES * 8;
  logic              byte_valid, frame_err;
  logic [7:0]        rx_byte;
  state_t            st_q, st_d;
  logic [5:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d, csum_nx, magic_exp;
  logic [31:0]       tmo_q, tmo_d;
  logic [FREQ_W-1:0] fsh_q, fsh_d, freq_q, freq_d;
  logic [DNA_W-1:0]  dsh_q, dsh_d, dna_q, dna_d;
  logic              osh_q, osh_d, otp_q, otp_d, core_q, core_d;
  logic              done_q, done_d, err_q, err_d, commit, abort;
  logic [1:0]        ec_q, ec_d;
  logic [2:0]        ch;
  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .frame_err(frame_err)
  );
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    csum_d = csum_q;
    fsh_d = fsh_q;
    dsh_d = dsh_q;
    osh_d = osh_q;
    ec_d = ec_q;
    commit = 1'b0;
    abort = 1'b0;
    ch = idx_q[4:2];
    csum_nx = csum_q ^ rx_byte;
    magic_exp = idx_q[1:0] == 2'd0 ? MAGIC_T : idx_q[1:0] == 2'd1 ? MAGIC_O : MAGIC_M;
    // tmo counts cycles elapsed since the last byte, so the byte cycle itself is cycle 0
    tmo_d = (st_q == ST_IDLE || byte_valid) ? 32'd1 : tmo_q + 32'd1;
    if (byte_valid) begin
      idx_d = idx_q + 6'd1;
      case (st_q)
        ST_IDLE: begin
          idx_d = '0;
          st_d = rx_byte == MAGIC_A ? ST_MAGIC : ST_IDLE;
        end
        ST_MAGIC: begin
          csum_d = '0;
          st_d = rx_byte != magic_exp ? ST_IDLE : idx_q == 6'd2 ? ST_VERSION : ST_MAGIC;
        end
        ST_VERSION: begin
          csum_d = csum_nx;
          idx_d = '0;
          st_d = ST_FREQ;
        end
        ST_FREQ: begin
          csum_d = csum_nx;
          fsh_d[32*ch +: 32] = {fsh_q[32*ch +: 24], rx_byte};
          if (idx_q == 6'(NUM_CH * 4 - 1)) begin
            idx_d = '0;
            st_d = ST_POLICY;
          end
        end
        ST_POLICY: begin
          csum_d = csum_nx;
          osh_d = rx_byte[0];
          idx_d = '0;
          st_d = ST_DNA;
        end
        ST_DNA: begin
          csum_d = csum_nx;
          dsh_d = DNA_W'({dsh_q, rx_byte});
          if (idx_q == 6'(DNA_BYTES - 1)) begin
`ifdef ATOMIK_LOADER_CHECKSUM_EN
            st_d = ST_CSUM;
`else
            commit = 1'b1;
`endif
          end
        end
`ifdef ATOMIK_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          commit = rx_byte == csum_q;
          abort = rx_byte != csum_q;
          ec_d = rx_byte == csum_q ? ec_q : ERR_CSUM;
        end
`endif
        default: st_d = ST_IDLE;
      endcase
    end
    if (frame_err && st_q != ST_IDLE) begin
      abort = 1'b1;
      ec_d = ERR_FRAME;
    end else if (!byte_valid && st_q != ST_IDLE && tmo_q == 32'(TIMEOUT_CYC - 1)) begin
      abort = 1'b1;
      ec_d = ERR_TIMEOUT;
    end
    ec_d = commit ? ERR_NONE : ec_d;
    st_d = (commit || abort) ? ST_IDLE : st_d;
    freq_d = commit ? fsh_d : freq_q;
    dna_d = commit ? dsh_d : dna_q;
    otp_d = commit ? osh_d : otp_q;
    core_d = core_q | commit;
    done_d = commit;
    err_d = abort;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_IDLE;
      idx_q <= '0;
      csum_q <= '0;
      tmo_q <= '0;
      fsh_q <= '0;
      dsh_q <= '0;
      osh_q <= 1'b0;
      freq_q <= '0;
      dna_q <= '0;
      otp_q <= 1'b0;
      core_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ec_q <= ERR_NONE;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      csum_q <= csum_d;
      tmo_q <= tmo_d;
      fsh_q <= fsh_d;
      dsh_q <= dsh_d;
      osh_q <= osh_d;
      freq_q <= freq_d;
      dna_q <= dna_d;
      otp_q <= otp_d;
      core_q <= core_d;
      done_q <= done_d;
      err_q <= err_d;
      ec_q <= ec_d;
    end
  end
  assign poly_freq_out = freq_q;
  assign dna_storage = dna_q;
  assign otp_en = otp_q;
  assign core_enable = core_q;
  assign loader_busy = st_q != ST_IDLE;
  assign load_done = done_q;
  assign load_err = err_q;
  assign err_code = ec_q;
endmodule

// File: tb/tb_uart_genome_loader_mc.sv
// tb_uart_genome_loader_mc: randomized UART frames checked against a frame-level model of the loader
module tb_uart_genome_loader_mc;
  import atomik_loader_pkg::*;
  localparam int CLK_FREQ = 27000000;
  localparam int BAUD = 1125000;
  localparam int BIT = 24;
  localparam int NUM_CH = 2;
  localparam int DNA_BYTES = 4;
  localparam int TMO = 1000;
  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
  logic [NUM_CH*32-1:0] poly_freq_out, exp_freq = '0;
  logic [DNA_BYTES*8-1:0] dna_storage, exp_dna = '0;
  logic otp_en, core_enable, loader_busy, load_done, load_err;
  logic exp_otp = 1'b0, exp_core = 1'b0;
  logic [1:0] err_code, exp_code = 2'd0;
  int n_cmp = 0, n_err = 0, done_cnt = 0, err_cnt = 0, exp_done = 0, exp_errs = 0;
  longint cyc = 0, bv_cyc = 0, le_cyc = 0;
  logic [31:0] fr_freq [NUM_CH];
  logic [7:0] fr_dna [DNA_BYTES];
  logic [7:0] fr_ver, fr_pol;
  logic [7:0] q [$];
  always #5 clk = ~clk;
  uart_genome_loader_mc #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .NUM_CH(NUM_CH),
    .DNA_BYTES(DNA_BYTES), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .poly_freq_out(poly_freq_out), .dna_storage(dna_storage), .otp_en(otp_en),
    .core_enable(core_enable), .loader_busy(loader_busy), .load_done(load_done),
    .load_err(load_err), .err_code(err_code)
  );
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dut.u_rx.byte_valid) bv_cyc <= cyc;
    if (load_done) done_cnt <= done_cnt + 1;
    if (load_err) begin
      err_cnt <= err_cnt + 1;
      le_cyc <= cyc;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, "_freq"}, 64'(poly_freq_out), 64'(exp_freq));
    check({tag, "_dna"}, 64'(dna_storage), 64'(exp_dna));
    check({tag, "_otp"}, 64'(otp_en), 64'(exp_otp));
    check({tag, "_core"}, 64'(core_enable), 64'(exp_core));
    check({tag, "_code"}, 64'(err_code), 64'(exp_code));
    check({tag, "_busy"}, 64'(loader_busy), 64'd0);
    check({tag, "_ndone"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_nerr"}, 64'(err_cnt), 64'(exp_errs));
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask
  task automatic send_q(input int n, input int bad);
    for (int i = 0; i < n; i++) begin
      send_byte(q[i], i != bad);
      if (i == bad) break;
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
  endtask
  task automatic rand_frame();
    fr_ver = 8'($urandom);
    fr_pol = 8'($urandom);
    for (int c = 0; c < NUM_CH; c++) fr_freq[c] = $urandom;
    for (int i = 0; i < DNA_BYTES; i++) fr_dna[i] = 8'($urandom);
  endtask
  task automatic build_frame(input bit bad_csum);
    logic [7:0] x;
    q.delete();
    q.push_back(8'h41);
    q.push_back(8'h54);
    q.push_back(8'h4F);
    q.push_back(8'h4D);
    q.push_back(fr_ver);
    x = fr_ver;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 3; k >= 0; k--) begin
        q.push_back(fr_freq[c][8*k +: 8]);
        x ^= fr_freq[c][8*k +: 8];
      end
    q.push_back(fr_pol);
    x ^= fr_pol;
    for (int i = 0; i < DNA_BYTES; i++) begin
      q.push_back(fr_dna[i]);
      x ^= fr_dna[i];
    end
`ifdef ATOMIK_LOADER_CHECKSUM_EN
    q.push_back(bad_csum ? x ^ 8'h01 : x);
`else
    if (bad_csum) q.push_back(x ^ 8'h01);
`endif
  endtask
  task automatic expect_commit();
    for (int c = 0; c < NUM_CH; c++) exp_freq[32*c +: 32] = fr_freq[c];
    for (int i = 0; i < DNA_BYTES; i++) exp_dna[8*(DNA_BYTES-1-i) +: 8] = fr_dna[i];
    exp_otp = fr_pol[0];
    exp_core = 1'b1;
    exp_code = 2'd0;
    exp_done++;
  endtask
  task automatic good_frame(input string tag);
    rand_frame();
    build_frame(1'b0);
    send_q(q.size(), -1);
    tick(10);
    expect_commit();
    check_all(tag);
  endtask
  initial begin
    int e0;
    tick(5);
    rst_n = 1'b1;
    tick(5);
    check_all("reset");
    check("phase_inc", 64'(phase_inc(27000000, 115200)), 64'd4474);
    fr_ver = 8'h02;
    fr_freq[0] = 32'h0000_0100;
    fr_freq[1] = 32'hDEAD_BEEF;
    fr_pol = 8'h01;
    fr_dna = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_frame(1'b0);
    send_q(q.size(), -1);
    tick(10);
    expect_commit();
    check_all("good");
    check("good_poly_lit", 64'(poly_freq_out), 64'hDEADBEEF_00000100);
    check("good_dna_lit", 64'(dna_storage), 64'h11223344);
    good_frame("rand0");
    good_frame("rand1");
`ifdef ATOMIK_LOADER_CHECKSUM_EN
    rand_frame();
    build_frame(1'b1);
    send_q(q.size(), -1);
    tick(10);
    exp_errs++;
    exp_code = 2'd2;
    check_all("bad_csum");
`endif
    rand_frame();
    build_frame(1'b0);
    send_q(8, 7);
    tick(300);
    exp_errs++;
    exp_code = 2'd1;
    check_all("frame_err");
    rand_frame();
    build_frame(1'b0);
    send_q(5, -1);
    tick(2);
    check("tmo_busy", 64'(loader_busy), 64'd1);
    e0 = exp_errs;
    for (int i = 0; i < 3 * TMO && err_cnt == e0; i++) tick(1);
    tick(2);
    exp_errs++;
    exp_code = 2'd3;
    check_all("timeout");
    check("tmo_latency", 64'(le_cyc - bv_cyc), 64'(TMO));
    q.delete();
    q.push_back(8'h41);
    q.push_back(8'h54);
    q.push_back(8'h58);
    send_q(3, -1);
    tick(50);
    check_all("bad_magic");
    good_frame("after_magic");
    rand_frame();
    build_frame(1'b0);
    send_q(16, -1);
    tick(2);
    check("dna_busy", 64'(loader_busy), 64'd1);
    rst_n = 1'b0;
    tick(3);
    exp_freq = '0;
    exp_dna = '0;
    exp_otp = 1'b0;
    exp_core = 1'b0;
    exp_code = 2'd0;
    check_all("in_reset");
    rst_n = 1'b1;
    tick(5);
    check_all("after_reset");
    good_frame("reset_frame");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
